// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between host logic and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  busy,
    input  tx_done,
    input  tx_err
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output busy,
    output tx_done,
    output tx_err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, requests to send, shifts
// out data/parity/stop on device clock falls and checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic         clk,
  input  logic         reset,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQ       = 3'd2,
    S_DATA      = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5,
    S_END       = 3'd6
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t           state_r, state_s;
  logic             clk_meta_r, clk_sync_r, clk_prev_r;
  logic             data_meta_r, data_sync_r;
  logic             fall_s, active_s, timeout_s;
  logic             done_s, err_s;
  logic [9:0]       frame_r;
  logic [3:0]       fall_cnt_r;
  logic [INH_W-1:0] inh_cnt_r;
  logic [TO_W-1:0]  to_cnt_r;
  logic             ready_s, busy_s, clk_oe_s, data_oe_s;
  logic             tx_ready_r, busy_r, tx_done_r, tx_err_r;
  logic             ps2_clk_oe_r, ps2_data_oe_r;

  assign fall_s    = clk_prev_r & ~clk_sync_r;
  assign active_s  = (state_r == S_REQ) || (state_r == S_DATA) ||
                     (state_r == S_ACK) || (state_r == S_WAIT_IDLE);
  assign timeout_s = active_s && (to_cnt_r == TO_LAST);

  // Two-flop synchronizers on the raw bus lines, plus the previous clock level for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      clk_prev_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk_in;
      clk_sync_r  <= clk_meta_r;
      clk_prev_r  <= clk_sync_r;
      data_meta_r <= ps2_data_in;
      data_sync_r <= data_meta_r;
    end
  end

  // Frame shift register and the inhibit, fall and timeout counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_r    <= 10'd0;
      fall_cnt_r <= 4'd0;
      inh_cnt_r  <= {INH_W{1'b0}};
      to_cnt_r   <= {TO_W{1'b0}};
    end else begin
      // Frame is {stop, parity, data}; bit 0 is what the next fall puts on the wire
      if ((state_r == S_IDLE) && tx.tx_valid) begin
        frame_r <= {1'b1, odd_parity(tx.tx_data), tx.tx_data};
      end else if (fall_s && ((state_r == S_REQ) || (state_r == S_DATA))) begin
        frame_r <= {1'b1, frame_r[9:1]};
      end else begin
        frame_r <= frame_r;
      end

      inh_cnt_r <= (state_r == S_INHIBIT) ? inh_cnt_r + INH_W'(1) : {INH_W{1'b0}};

      case (state_r)
        S_REQ:   fall_cnt_r <= fall_s ? 4'd1 : 4'd0;
        S_DATA:  fall_cnt_r <= fall_s ? fall_cnt_r + 4'd1 : fall_cnt_r;
        default: fall_cnt_r <= 4'd0;
      endcase

      if (active_s && !timeout_s) begin
        to_cnt_r <= fall_s ? {TO_W{1'b0}} : to_cnt_r + TO_W'(1);
      end else begin
        to_cnt_r <= {TO_W{1'b0}};
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; timeout wins over a simultaneous fall in every active state
  always_comb begin
    state_s = state_r;
    done_s  = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (tx.tx_valid) state_s = S_INHIBIT;
        else             state_s = S_IDLE;
      end
      S_INHIBIT: begin
        if (inh_cnt_r == INH_LAST) state_s = S_REQ;
        else                       state_s = S_INHIBIT;
      end
      S_REQ: begin
        if (timeout_s) begin
          state_s = S_END;
          err_s   = 1'b1;
        end else if (fall_s) begin
          state_s = S_DATA;
        end else begin
          state_s = S_REQ;
        end
      end
      S_DATA: begin
        if (timeout_s) begin
          state_s = S_END;
          err_s   = 1'b1;
        end else if (fall_s && (fall_cnt_r == 4'd9)) begin
          state_s = S_ACK;
        end else begin
          state_s = S_DATA;
        end
      end
      S_ACK: begin
        if (timeout_s) begin
          state_s = S_END;
          err_s   = 1'b1;
        end else if (fall_s && data_sync_r) begin
          state_s = S_END;
          err_s   = 1'b1;
        end else if (fall_s) begin
          state_s = S_WAIT_IDLE;
        end else begin
          state_s = S_ACK;
        end
      end
      S_WAIT_IDLE: begin
        if (timeout_s) begin
          state_s = S_END;
          err_s   = 1'b1;
        end else if (clk_sync_r && data_sync_r) begin
          state_s = S_END;
          done_s  = 1'b1;
        end else begin
          state_s = S_WAIT_IDLE;
        end
      end
      // One busy cycle carrying the result pulse, so tx_ready rises the cycle after it
      S_END:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Next output values derived from the upcoming state
  always_comb begin
    ready_s   = 1'b0;
    busy_s    = 1'b1;
    clk_oe_s  = 1'b0;
    data_oe_s = 1'b0;
    case (state_s)
      S_IDLE: begin
        ready_s = 1'b1;
        busy_s  = 1'b0;
      end
      S_INHIBIT: clk_oe_s  = 1'b1;
      S_REQ:     data_oe_s = 1'b1;
      S_DATA: begin
        if (fall_s) data_oe_s = ~frame_r[0];
        else        data_oe_s = ps2_data_oe_r;
      end
      default: data_oe_s = 1'b0;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_ready_r    <= 1'b1;
      busy_r        <= 1'b0;
      tx_done_r     <= 1'b0;
      tx_err_r      <= 1'b0;
      ps2_clk_oe_r  <= 1'b0;
      ps2_data_oe_r <= 1'b0;
    end else begin
      tx_ready_r    <= ready_s;
      busy_r        <= busy_s;
      tx_done_r     <= done_s;
      tx_err_r      <= err_s;
      ps2_clk_oe_r  <= clk_oe_s;
      ps2_data_oe_r <= data_oe_s;
    end
  end

  assign tx.tx_ready  = tx_ready_r;
  assign tx.busy      = busy_r;
  assign tx.tx_done   = tx_done_r;
  assign tx.tx_err    = tx_err_r;
  assign ps2_clk_oe   = ps2_clk_oe_r;
  assign ps2_data_oe  = ps2_data_oe_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with an open-drain PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int TO  = 200;
  localparam int M_NORMAL = 0, M_NACK = 1, M_STALL = 2, M_RESET = 3;

  typedef struct {
    logic [7:0] b;
    int         mode;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ps2_clk_oe, ps2_data_oe;
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic clk_line, data_line;

  assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx_if txi();

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .tx(txi),
    .ps2_clk_in(clk_line), .ps2_data_in(data_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        exp_q[$];
  int          dev_mode_q[$];
  logic [10:0] cap_q[$];
  int          last_fall_cyc = 0;
  bit          dev_at_bit5 = 1'b0, dev_resume = 1'b0;
  int          busy_ready_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Device model: waits for a request-to-send, clocks 11 falls, samples on rises, drives ACK
  initial begin : device
    int mode;
    logic [10:0] cap;
    bit aborted;
    forever begin
      @(negedge clk);
      if (reset && !clk_line && ps2_clk_oe) begin
        while (!(clk_line && !data_line)) @(negedge clk);
        mode = (dev_mode_q.size() > 0) ? dev_mode_q.pop_front() : M_NORMAL;
        cap = 11'd0;
        cap[0] = data_line;
        aborted = 1'b0;
        repeat (10) @(negedge clk);
        for (int k = 1; k <= 10 && !aborted; k++) begin
          if (mode == M_STALL && k == 5) begin
            aborted = 1'b1;
          end else begin
            dev_clk_low = 1'b1;
            last_fall_cyc = cyc;
            repeat (20) @(negedge clk);
            if (mode == M_RESET && k == 6) begin
              dev_at_bit5 = 1'b1;
              while (!dev_resume) @(negedge clk);
              dev_clk_low = 1'b0;
              dev_at_bit5 = 1'b0;
              aborted = 1'b1;
            end else begin
              dev_clk_low = 1'b0;
              cap[k] = data_line;
              repeat ((k == 10) ? 10 : 20) @(negedge clk);
            end
          end
        end
        if (!aborted) begin
          cap_q.push_back(cap);
          if (mode != M_NACK) dev_data_low = 1'b1;
          repeat (10) @(negedge clk);
          dev_clk_low = 1'b1;
          last_fall_cyc = cyc;
          repeat (20) @(negedge clk);
          dev_clk_low = 1'b0;
          repeat (5) @(negedge clk);
          dev_data_low = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every result pulse and checks framing, timing, busy
  initial begin : monitor
    exp_t e;
    logic [10:0] cap;
    bit check_next = 1'b0, started = 1'b0, gap = 1'b0, inh_data = 1'b0;
    int inh_run = 0;
    int d;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check_next = 1'b0; started = 1'b0; gap = 1'b0; inh_run = 0; inh_data = 1'b0;
      end else begin
        if (check_next) begin
          chk("ready_after_pulse", txi.tx_ready, 1);
          chk("lines_released_after_pulse", {ps2_clk_oe, ps2_data_oe}, 0);
          chk("pulse_single_cycle", {txi.tx_done, txi.tx_err}, 0);
          check_next = 1'b0;
        end
        if (txi.busy == txi.tx_ready) busy_ready_bad++;
        if (ps2_clk_oe) begin
          inh_run++;
          if (ps2_data_oe) inh_data = 1'b1;
        end else if (inh_run > 0) begin
          chk("inhibit_length", inh_run, INH);
          chk("data_released_in_inhibit", inh_data, 0);
          inh_run = 0;
          inh_data = 1'b0;
        end
        if (exp_q.size() > 0 && txi.busy) started = 1'b1;
        if (started && !txi.busy) gap = 1'b1;
        if (txi.tx_done || txi.tx_err) begin
          chk("done_err_exclusive", txi.tx_done & txi.tx_err, 0);
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_pulse: done=%0d err=%0d, required no pulse", txi.tx_done, txi.tx_err);
          end else begin
            e = exp_q.pop_front();
            chk("pulse_is_done", txi.tx_done, (e.mode == M_NORMAL) ? 1 : 0);
            chk("pulse_is_err", txi.tx_err, (e.mode == M_NORMAL) ? 0 : 1);
            chk("busy_held_through_frame", gap, 0);
            if (e.mode == M_STALL) begin
              d = cyc - last_fall_cyc;
              compared++;
              if (d < TO || d > TO + 4) begin
                mismatched++;
                $display("FAIL timeout_delay: got %0d cycles after last fall, required %0d..%0d", d, TO, TO + 4);
              end
            end else if (cap_q.size() == 0) begin
              compared++;
              mismatched++;
              $display("FAIL missing_frame: device captured nothing, required byte %02h", e.b);
            end else begin
              cap = cap_q.pop_front();
              chk("start_bit", cap[0], 0);
              chk("data_byte", cap[8:1], e.b);
              chk("parity_bit", cap[9], ($countones(e.b) % 2 == 0) ? 1 : 0);
              chk("stop_bit", cap[10], 1);
            end
          end
          check_next = 1'b1;
          started = 1'b0;
          gap = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input int mode, input bit keep);
    exp_t e;
    int n;
    e.b = b;
    e.mode = mode;
    if (mode != M_RESET) exp_q.push_back(e);
    dev_mode_q.push_back(mode);
    txi.tx_data = b;
    txi.tx_valid = 1'b1;
    n = 0;
    while (!txi.tx_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: byte %02h never accepted, required tx_ready", b);
    end
    @(posedge clk);
    @(negedge clk);
    if (!keep) txi.tx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      compared++;
      mismatched++;
      $display("FAIL completion_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (80) @(negedge clk);
  endtask

  initial begin : stim
    int n;
    logic [7:0] rb;
    txi.tx_valid = 1'b0;
    txi.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_tx_ready", txi.tx_ready, 1);
    chk("reset_busy", txi.busy, 0);
    chk("reset_pulses", {txi.tx_done, txi.tx_err}, 0);
    chk("reset_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    send(8'hED, M_NORMAL, 1'b0); wait_done();
    send(8'h00, M_NORMAL, 1'b0); wait_done();
    send(8'hFF, M_NORMAL, 1'b0); wait_done();
    send(8'h01, M_NORMAL, 1'b0); wait_done();
    send(8'hF4, M_NACK, 1'b0);   wait_done();
    send(8'hA5, M_STALL, 1'b0);  wait_done();
    send(8'hFF, M_NORMAL, 1'b0); wait_done();

    // Reset while the device holds the clock low during bit 5 (bit 5 of 0x1C is 0)
    send(8'h1C, M_RESET, 1'b0);
    n = 0;
    while (!dev_at_bit5 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_bit5", dev_at_bit5, 1);
    chk("bit5_driven_low", ps2_data_oe, 1);
    #1 reset = 1'b0;
    #1;
    chk("async_clk_oe_release", ps2_clk_oe, 0);
    chk("async_data_oe_release", ps2_data_oe, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    dev_resume = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", txi.tx_ready, 1);
    chk("post_reset_busy", txi.busy, 0);
    n = 0;
    while (dev_at_bit5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    dev_resume = 1'b0;
    repeat (300) @(negedge clk);

    send(8'hAA, M_NORMAL, 1'b1);
    send(8'h55, M_NORMAL, 1'b0);
    wait_done();

    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom_range(0, 255));
      send(rb, ($urandom_range(0, 3) == 0) ? M_NACK : M_NORMAL, 1'b0);
      wait_done();
    end

    chk("busy_is_not_ready_always", busy_ready_bad, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("captures_drained", cap_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the top design to the attached keyboard over the same PS2_clk/PS2_data pair the existing keyboard receiver listens on. It drives both lines open-drain through active-high pull-low enables. `busy` tells the receiver to ignore bus activity while a transmission is in flight.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles the PS/2 clock line is held low before the start bit (100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, maximum clk cycles between successive PS/2 clock falling edges after the clock line is released (15 ms at 50 MHz).

Ports:
clk  input  1  system clock, 50 MHz.
reset  input  1  asynchronous, active-low reset.
tx_data  input  8  command byte to send.
tx_valid  input  1  request; a byte is accepted when tx_valid && tx_ready.
tx_ready  output  1  high only in IDLE.
busy  output  1  high in every state except IDLE.
tx_done  output  1  one-cycle pulse: frame sent and device ACK seen.
tx_err  output  1  one-cycle pulse: ACK missing or timeout.
ps2_clk_in  input  1  raw PS2_clk line level.
ps2_data_in  input  1  raw PS2_data line level.
ps2_clk_oe  output  1  1 = pull PS2_clk low; 0 = release.
ps2_data_oe  output  1  1 = pull PS2_data low; 0 = release.

Behaviour:
- Reset (reset=0, async): state=IDLE; tx_ready=1; busy=0; tx_done=0; tx_err=0; ps2_clk_oe=0; ps2_data_oe=0; counters=0; synchronizers=1. Reset mid-frame releases both lines immediately and produces no tx_done/tx_err pulse.
- ps2_clk_in and ps2_data_in each pass through a 2-FF synchronizer.
- fall = synced clock was 1 last cycle and is 0 this cycle.
- Accept: in IDLE with tx_valid=1, latch tx_data, compute odd parity p = ~^tx_data, go to INHIBIT. tx_valid is ignored outside IDLE.
- INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles. On the last cycle, transition to REQ.
- REQ (start bit): ps2_clk_oe=0, ps2_data_oe=1. Bit index=0. Timeout counter cleared.
- Frame, driven on PS/2 clock falling edges:
  - Falls 1-8: drive data bit 0..7, LSB first. ps2_data_oe = ~bit.
  - Fall 9: drive parity, ps2_data_oe = ~p.
  - Fall 10: stop bit, ps2_data_oe=0. Enter ACK.
  - Fall 11 (in ACK): sample synced data.
    - 0: go to WAIT_IDLE.
    - 1: pulse tx_err, release lines, go to IDLE.
- Each line change lands one cycle after `fall` is detected, i.e. 3 clk after the raw edge. Device sampling happens at the following rising edge, so this latency is acceptable.
- WAIT_IDLE: wait until synced clock=1 and data=1, then pulse tx_done for one cycle and go to IDLE.
- Timeout: in REQ/DATA/ACK/WAIT_IDLE, the counter increments every cycle without `fall` and clears on `fall`. When it reaches TIMEOUT_CYCLES-1:
  - release both lines,
  - pulse tx_err,
  - go to IDLE.
  The timeout takes priority over a simultaneous `fall`.
- tx_done and tx_err are never high together. tx_ready asserts the cycle after either pulse.
- Counter widths: ceil(log2(param)) bits; must not wrap before the compare.
- In IDLE, bus activity from the device is ignored; the block never drives in IDLE.

Test Plan:
(Bench overrides INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200. Device model: 40-cycle PS/2 clock period, samples data on rising edges, drives ACK.)
1. Send 0xED -> ps2_clk_oe high exactly 20 cycles. Device samples start=0, bits 1,0,1,1,0,1,1,1, parity=1, stop=1. ACK=0 -> exactly one tx_done pulse; tx_err stays 0.
2. Send 0x00 -> parity bit=1. Send 0xFF -> parity bit=1. Send 0x01 -> parity bit=0. All complete with tx_done.
3. Device model drives ACK=1 for 0xF4 -> one tx_err pulse, no tx_done, both oe=0, tx_ready=1 next cycle.
4. Device stops clocking after bit 3 -> tx_err exactly 200 cycles after the last falling edge; lines released; a following 0xFF transmits normally.
5. Assert reset low during bit 5 -> ps2_clk_oe and ps2_data_oe go 0 asynchronously (same timestep). After release, tx_ready=1 and no pulses are seen.
6. Hold tx_valid high with 0xAA then 0x55 back-to-back -> 0xAA fully sent first; 0x55 accepted only when tx_ready returns; busy high throughout each frame.
